// File: rtl/icmp_pkg.sv
// Shared ICMP/IPv4 definitions for the echo filter and the echo responder.
package icmp_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned EMPTY_W = 2;

    typedef enum logic [2:0] {
        S_HDR,
        S_DECIDE,
        S_FWD_HDR,
        S_FWD_BODY,
        S_DROP
    } state_t;

    localparam logic [7:0] IPV4_VER_IHL    = 8'h45;
    localparam logic [7:0] IP_PROTO_ICMP   = 8'h01;
    localparam logic [7:0] ICMP_ECHO_REQ   = 8'h08;
    localparam logic [7:0] ICMP_ECHO_REPLY = 8'h00;

    // Word index / byte lane of each field inside the buffered header.
    localparam int unsigned VER_WORD   = 0;
    localparam int unsigned VER_BYTE   = 0;
    localparam int unsigned PROTO_WORD = 2;
    localparam int unsigned PROTO_BYTE = 1;
    localparam int unsigned DST_WORD   = 4;
    localparam int unsigned TYPE_WORD  = 5;
    localparam int unsigned TYPE_BYTE  = 0;

    // Byte lane b of a stream word (lane 0 is first on the wire).
    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] w, input logic [1:0] b);
        return w[{b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/icmp_hdr_match.sv
// Combinational check that a buffered header is an IPv4 ICMP echo request to local_ip.
module icmp_hdr_match
    import icmp_pkg::*;
#(
    parameter int unsigned HDR_WORDS = 6
) (
    input  logic [DATA_W-1:0] hdr_buf_i [HDR_WORDS],
    input  logic [DATA_W-1:0] local_ip_i,
    output logic              match_c
);

    logic unused_bits;

    // Field compare on version/IHL, protocol, destination address and ICMP type.
    always_comb begin
        match_c = (get_byte(hdr_buf_i[VER_WORD],   2'(VER_BYTE))   == IPV4_VER_IHL)  &&
                  (get_byte(hdr_buf_i[PROTO_WORD], 2'(PROTO_BYTE)) == IP_PROTO_ICMP) &&
                  (hdr_buf_i[DST_WORD] == local_ip_i)                                 &&
                  (get_byte(hdr_buf_i[TYPE_WORD],  2'(TYPE_BYTE))  == ICMP_ECHO_REQ);
    end

    // Header words and lanes that carry no matched field.
    always_comb begin
        unused_bits = 1'b0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            unused_bits = unused_bits ^ (^hdr_buf_i[i]);
        end
    end

endmodule

// File: rtl/icmp_echo_filter.sv
// Ingress filter: forwards only IPv4 ICMP echo requests addressed to local_ip.
module icmp_echo_filter
    import icmp_pkg::*;
#(
    parameter int unsigned HDR_WORDS = 6,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_W-1:0]    local_ip,
    input  logic [DATA_W-1:0]    stream_in_data,
    input  logic [EMPTY_W-1:0]   stream_in_empty,
    input  logic                 stream_in_valid,
    input  logic                 stream_in_startofpacket,
    input  logic                 stream_in_endofpacket,
    output logic                 stream_in_ready,
    output logic [DATA_W-1:0]    stream_out_data,
    output logic [EMPTY_W-1:0]   stream_out_empty,
    output logic                 stream_out_valid,
    output logic                 stream_out_startofpacket,
    output logic                 stream_out_endofpacket,
    input  logic                 stream_out_ready,
    output logic [CNT_WIDTH-1:0] pass_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned    HC_W    = $clog2(HDR_WORDS + 1);
    localparam int unsigned    TX_W    = $clog2(HDR_WORDS);
    localparam logic [HC_W-1:0] HC_FULL = HC_W'(HDR_WORDS);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HDR_WORDS - 1);
    localparam logic [TX_W-1:0] TX_LAST = TX_W'(HDR_WORDS - 1);

    state_t               state_q, state_d;
    logic [HC_W-1:0]      hdr_cnt_q, hdr_cnt_d;
    logic [DATA_W-1:0]    hdr_buf_q [HDR_WORDS];
    logic [DATA_W-1:0]    hdr_buf_d [HDR_WORDS];
    logic                 eop_seen_q, eop_seen_d;
    logic [EMPTY_W-1:0]   saved_empty_q, saved_empty_d;
    logic [TX_W-1:0]      tx_idx_q, tx_idx_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [EMPTY_W-1:0]   out_empty_q, out_empty_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic [CNT_WIDTH-1:0] pass_q, pass_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic                 match_c;
    logic                 out_free;
    logic                 tx_last;
    logic [HC_W-1:0]      wr_idx;

    icmp_hdr_match #(
        .HDR_WORDS (HDR_WORDS)
    ) u_match (
        .hdr_buf_i  (hdr_buf_q),
        .local_ip_i (local_ip),
        .match_c    (match_c)
    );

    // Next-state, header capture, output register load and counters.
    always_comb begin
        state_d       = state_q;
        hdr_cnt_d     = hdr_cnt_q;
        hdr_buf_d     = hdr_buf_q;
        eop_seen_d    = eop_seen_q;
        saved_empty_d = saved_empty_q;
        tx_idx_d      = tx_idx_q;
        out_valid_d   = out_valid_q & ~stream_out_ready;
        out_data_d    = out_data_q;
        out_empty_d   = out_empty_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        pass_d        = pass_q;
        drop_d        = drop_q;
        stream_in_ready = 1'b0;
        out_free      = ~out_valid_q | stream_out_ready;
        tx_last       = (tx_idx_q == TX_LAST);
        wr_idx        = '0;

        case (state_q)
            S_HDR: begin
                stream_in_ready = 1'b1;
                // Words ahead of the first sop are discarded silently.
                if (stream_in_valid && (stream_in_startofpacket || hdr_cnt_q != '0)) begin
                    wr_idx            = stream_in_startofpacket ? '0 : hdr_cnt_q;
                    hdr_buf_d[wr_idx] = stream_in_data;
                    hdr_cnt_d         = wr_idx + HC_W'(1);
                    eop_seen_d        = stream_in_endofpacket;
                    saved_empty_d     = stream_in_empty;
                    if (stream_in_endofpacket || wr_idx == HC_LAST) begin
                        state_d = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                hdr_cnt_d = '0;
                if (match_c && hdr_cnt_q == HC_FULL) begin
                    pass_d   = pass_q + CNT_WIDTH'(1);
                    tx_idx_d = '0;
                    state_d  = S_FWD_HDR;
                end else if (eop_seen_q) begin
                    drop_d  = drop_q + CNT_WIDTH'(1);
                    state_d = S_HDR;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_FWD_HDR: begin
                // Replay one buffered word whenever the output slot frees up.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_buf_q[tx_idx_q];
                    out_sop_d   = (tx_idx_q == '0);
                    out_eop_d   = tx_last & eop_seen_q;
                    out_empty_d = (tx_last & eop_seen_q) ? saved_empty_q : '0;
                    tx_idx_d    = tx_idx_q + TX_W'(1);
                    if (tx_last) begin
                        state_d = eop_seen_q ? S_HDR : S_FWD_BODY;
                    end
                end
            end
            S_FWD_BODY: begin
                stream_in_ready = out_free;
                if (stream_in_valid && out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = stream_in_data;
                    out_sop_d   = 1'b0;
                    out_eop_d   = stream_in_endofpacket;
                    out_empty_d = stream_in_empty;
                    if (stream_in_endofpacket) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_DROP: begin
                stream_in_ready = 1'b1;
                if (stream_in_valid && stream_in_endofpacket) begin
                    drop_d  = drop_q + CNT_WIDTH'(1);
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    // State, buffer, output and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_HDR;
            hdr_cnt_q     <= '0;
            hdr_buf_q     <= '{default: '0};
            eop_seen_q    <= 1'b0;
            saved_empty_q <= '0;
            tx_idx_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_empty_q   <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            pass_q        <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            hdr_cnt_q     <= hdr_cnt_d;
            hdr_buf_q     <= hdr_buf_d;
            eop_seen_q    <= eop_seen_d;
            saved_empty_q <= saved_empty_d;
            tx_idx_q      <= tx_idx_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_empty_q   <= out_empty_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            pass_q        <= pass_d;
            drop_q        <= drop_d;
        end
    end

    assign stream_out_data          = out_data_q;
    assign stream_out_empty         = out_empty_q;
    assign stream_out_valid         = out_valid_q;
    assign stream_out_startofpacket = out_sop_q;
    assign stream_out_endofpacket   = out_eop_q;
    assign pass_count               = pass_q;
    assign drop_count               = drop_q;

endmodule

// File: tb/tb_icmp_echo_filter.sv
// Directed bench for icmp_echo_filter with an expected-output queue.
module tb_icmp_echo_filter;

    localparam logic [31:0] LOCAL_IP = 32'h0100A8C0;

    logic        clk;
    logic        reset_n;
    logic [31:0] local_ip;
    logic [31:0] stream_in_data;
    logic [1:0]  stream_in_empty;
    logic        stream_in_valid;
    logic        stream_in_startofpacket;
    logic        stream_in_endofpacket;
    logic        stream_in_ready;
    logic [31:0] stream_out_data;
    logic [1:0]  stream_out_empty;
    logic        stream_out_valid;
    logic        stream_out_startofpacket;
    logic        stream_out_endofpacket;
    logic        stream_out_ready;
    logic [15:0] pass_count;
    logic [15:0] drop_count;

    int          n_checks;
    int          n_fail;
    int          valid_cnt;
    bit          rnd_mode;
    bit          stall_prev;
    logic [35:0] stall_word;
    logic [31:0] pkt[$];
    logic [35:0] exp_q[$];
    logic [35:0] rx_q[$];

    icmp_echo_filter dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .local_ip                 (local_ip),
        .stream_in_data           (stream_in_data),
        .stream_in_empty          (stream_in_empty),
        .stream_in_valid          (stream_in_valid),
        .stream_in_startofpacket  (stream_in_startofpacket),
        .stream_in_endofpacket    (stream_in_endofpacket),
        .stream_in_ready          (stream_in_ready),
        .stream_out_data          (stream_out_data),
        .stream_out_empty         (stream_out_empty),
        .stream_out_valid         (stream_out_valid),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_ready         (stream_out_ready),
        .pass_count               (pass_count),
        .drop_count               (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records transfers and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_valid", 64'(stream_out_valid), 64'd1);
                check_eq("stall_word", 64'({stream_out_data, stream_out_empty,
                         stream_out_startofpacket, stream_out_endofpacket}), 64'(stall_word));
            end
            if (stream_out_valid) begin
                valid_cnt++;
                if (stream_out_ready)
                    rx_q.push_back({stream_out_data, stream_out_empty,
                                    stream_out_startofpacket, stream_out_endofpacket});
            end
            stall_prev = stream_out_valid & ~stream_out_ready;
            stall_word = {stream_out_data, stream_out_empty,
                          stream_out_startofpacket, stream_out_endofpacket};
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) stream_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic make_pkt(input int len, input logic [7:0] vi, input logic [7:0] pr,
                            input logic [31:0] dst, input logic [7:0] ty, input logic [7:0] tg);
        logic [31:0] w;
        pkt.delete();
        for (int i = 0; i < len; i++) begin
            w = {tg, 8'(i), 8'hC3, 8'(i + 1)};
            if (i == 0) w[7:0]  = vi;
            if (i == 2) w[15:8] = pr;
            if (i == 4) w       = dst;
            if (i == 5) w[7:0]  = ty;
            pkt.push_back(w);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] e, input bit s, input bit eo);
        bit rdy;
        int n;
        stream_in_data          = d;
        stream_in_empty         = e;
        stream_in_startofpacket = s;
        stream_in_endofpacket   = eo;
        stream_in_valid         = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = stream_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) check_eq("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_pkt(input logic [1:0] emp);
        int last;
        last = pkt.size() - 1;
        for (int i = 0; i <= last; i++)
            send_word(pkt[i], (i == last) ? emp : 2'b00, i == 0, i == last);
        stream_in_valid         = 1'b0;
        stream_in_startofpacket = 1'b0;
        stream_in_endofpacket   = 1'b0;
    endtask

    task automatic expect_pkt(input logic [1:0] emp);
        int last;
        last = pkt.size() - 1;
        for (int i = 0; i <= last; i++)
            exp_q.push_back({pkt[i], (i == last) ? emp : 2'b00, i == 0, i == last});
    endtask

    task automatic drain(input string tag);
        int n;
        int m;
        n = 0;
        while (rx_q.size() < exp_q.size() && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_words"}, 64'(rx_q.size()), 64'(exp_q.size()));
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check_eq($sformatf("%s_w%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag, input int p, input int d);
        check_eq({tag, "_pass"}, 64'(pass_count), 64'(p));
        check_eq({tag, "_drop"}, 64'(drop_count), 64'(d));
    endtask

    initial begin
        int v0;
        n_checks = 0;
        n_fail   = 0;
        valid_cnt = 0;
        rnd_mode = 1'b0;
        reset_n  = 1'b0;
        local_ip = LOCAL_IP;
        stream_in_data = '0;
        stream_in_empty = '0;
        stream_in_valid = 1'b0;
        stream_in_startofpacket = 1'b0;
        stream_in_endofpacket = 1'b0;
        stream_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(stream_out_valid), 64'd0);
        check_eq("rst_out_data", 64'(stream_out_data), 64'd0);
        check_eq("rst_in_ready", 64'(stream_in_ready), 64'd1);
        check_counts("rst", 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Echo request, 10 words, empty 2.
        make_pkt(10, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h10);
        expect_pkt(2'd2);
        send_pkt(2'd2);
        drain("echo10");
        check_counts("echo10", 1, 0);

        // Echo reply is dropped with no output activity.
        v0 = valid_cnt;
        make_pkt(10, 8'h45, 8'h01, LOCAL_IP, 8'h00, 8'h20);
        send_pkt(2'd2);
        drain("reply");
        check_eq("reply_no_valid", 64'(valid_cnt - v0), 64'd0);
        check_counts("reply", 1, 1);

        // One mismatching field per packet.
        make_pkt(10, 8'h45, 8'h01, 32'h0200A8C0, 8'h08, 8'h30);
        send_pkt(2'd0);
        make_pkt(10, 8'h45, 8'h06, LOCAL_IP, 8'h08, 8'h31);
        send_pkt(2'd1);
        make_pkt(10, 8'h46, 8'h01, LOCAL_IP, 8'h08, 8'h32);
        send_pkt(2'd3);
        drain("mism");
        check_counts("mism", 1, 4);

        // Stray words with no sop are discarded without counting.
        send_word(32'hDEAD0001, 2'd0, 1'b0, 1'b0);
        send_word(32'hDEAD0002, 2'd0, 1'b0, 1'b1);
        stream_in_valid = 1'b0;
        stream_in_endofpacket = 1'b0;
        drain("stray");
        check_counts("stray", 1, 4);

        // Short packet dropped; 6-word echo carries eop and saved empty on word 5.
        make_pkt(4, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h40);
        send_pkt(2'd1);
        make_pkt(6, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h41);
        expect_pkt(2'd3);
        send_pkt(2'd3);
        drain("short");
        check_counts("short", 2, 5);

        // 20-word echo under random backpressure.
        rnd_mode = 1'b1;
        make_pkt(20, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h50);
        expect_pkt(2'd1);
        send_pkt(2'd1);
        drain("bp20");
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        stream_out_ready = 1'b1;
        check_counts("bp20", 3, 5);

        // Reset while the fourth header word is being presented.
        stream_out_ready = 1'b0;
        make_pkt(10, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h60);
        for (int i = 0; i < 6; i++) send_word(pkt[i], 2'd0, i == 0, 1'b0);
        stream_in_valid = 1'b0;
        stream_in_startofpacket = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("fh_word0", 64'(stream_out_data), 64'(pkt[0]));
        for (int k = 0; k < 3; k++) begin
            stream_out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        stream_out_ready = 1'b0;
        check_eq("fh_word3", 64'(stream_out_data), 64'(pkt[3]));
        check_eq("fh_word3_sop", 64'(stream_out_startofpacket), 64'd0);
        check_eq("pre_rst_pass", 64'(pass_count), 64'd4);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(stream_out_valid), 64'd0);
        check_eq("mid_rst_eop", 64'(stream_out_endofpacket), 64'd0);
        check_counts("mid_rst", 0, 0);
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stream_out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back echo, drop, echo after reset.
        make_pkt(8, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h70);
        expect_pkt(2'd1);
        send_pkt(2'd1);
        make_pkt(7, 8'h45, 8'h01, LOCAL_IP, 8'h00, 8'h71);
        send_pkt(2'd2);
        make_pkt(12, 8'h45, 8'h01, LOCAL_IP, 8'h08, 8'h72);
        expect_pkt(2'd0);
        send_pkt(2'd0);
        drain("b2b");
        check_counts("b2b", 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
